// File: rtl/wb_stream_pkg.sv
// Shared Wishbone burst encodings and FSM state type for the stream writer datapath.
package wb_stream_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        DONE
    } state_t;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data always shows the head word.
module stream_fifo #(
    parameter int WB_DW   = 32,
    parameter int FIFO_AW = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WB_DW-1:0]   wr_data,
    input  logic               wr_en,
    input  logic               rd_en,
    output logic [WB_DW-1:0]   rd_data,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;

    logic [WB_DW-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               push;
    logic               pop;

    assign full    = (count == (FIFO_AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_stream_writer.sv
// Buffers a valid/ready word stream and writes it out as Wishbone incrementing bursts.
// Define WB_STREAM_WRITER_STATS_EN to add the words_written_o / overflow_o statistics ports.
module wb_stream_writer
    import wb_stream_pkg::*;
#(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 6,
    parameter int MAX_BURST_LEN = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [WB_DW-1:0]     stream_s_data_i,
    input  logic                 stream_s_valid_i,
    output logic                 stream_s_ready_o,
    input  logic                 enable_i,
    input  logic [WB_AW-1:0]     start_adr_i,
    input  logic [WB_AW-1:0]     buf_size_i,
    output logic                 busy_o,
    output logic                 irq_o,
    output logic                 err_o,
`ifdef WB_STREAM_WRITER_STATS_EN
    output logic [31:0]          words_written_o,
    output logic                 overflow_o,
`endif
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW-1:0]     wbm_dat_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i
);

    localparam int BL_W = $clog2(MAX_BURST_LEN + 1);
    localparam logic [WB_AW-1:0] ADR_STEP = WB_AW'(WB_DW / 8);
    localparam logic [WB_AW-1:0] MAX_LEN  = WB_AW'(MAX_BURST_LEN);

    state_t             state;
    logic               enable_q;
    logic [WB_AW-1:0]   adr;
    logic [WB_AW-1:0]   remaining;
    logic [BL_W-1:0]    beats;
    logic [WB_AW-1:0]   blen;
    logic               burst_ready;
    logic               start_edge;
    logic               pop;

    logic [WB_DW-1:0]   fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FIFO_AW:0]   fifo_count;

    stream_fifo #(
        .WB_DW   (WB_DW),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .wr_data (stream_s_data_i),
        .wr_en   (stream_s_valid_i),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        blen        = (remaining < MAX_LEN) ? remaining : MAX_LEN;
        burst_ready = (WB_AW'(fifo_count) >= blen);
        start_edge  = (state == IDLE) && enable_i && !enable_q;
        pop         = (state == BURST) && wbm_ack_i && !wbm_err_i && !fifo_empty;
    end

    assign stream_s_ready_o = !fifo_full;
    assign wbm_adr_o        = adr;
    assign wbm_dat_o        = wbm_cyc_o ? fifo_head : '0;
    assign wbm_bte_o        = BTE_LINEAR;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            enable_q  <= 1'b0;
            adr       <= '0;
            remaining <= '0;
            beats     <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_cti_o <= CTI_CLASSIC;
            busy_o    <= 1'b0;
            irq_o     <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            enable_q <= enable_i;
            irq_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        adr       <= start_adr_i;
                        remaining <= buf_size_i;
                        err_o     <= 1'b0;
                        busy_o    <= 1'b1;
                        if (buf_size_i == '0) begin
                            irq_o <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (burst_ready) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b1;
                        wbm_sel_o <= '1;
                        beats     <= BL_W'(blen);
                        wbm_cti_o <= (blen == WB_AW'(1)) ? CTI_EOB : CTI_INC;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    // err has priority over a simultaneous ack: abort without popping
                    if (wbm_err_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= '0;
                        wbm_cti_o <= CTI_CLASSIC;
                        err_o     <= 1'b1;
                        busy_o    <= 1'b0;
                        state     <= IDLE;
                    end else if (wbm_ack_i) begin
                        adr       <= adr + ADR_STEP;
                        remaining <= remaining - 1'b1;
                        beats     <= beats - 1'b1;
                        if (beats == BL_W'(1)) begin
                            wbm_cyc_o <= 1'b0;
                            wbm_stb_o <= 1'b0;
                            wbm_we_o  <= 1'b0;
                            wbm_sel_o <= '0;
                            wbm_cti_o <= CTI_CLASSIC;
                            if (remaining == WB_AW'(1)) begin
                                irq_o <= 1'b1;
                                state <= DONE;
                            end else begin
                                state <= WAIT;
                            end
                        end else if (beats == BL_W'(2)) begin
                            wbm_cti_o <= CTI_EOB;
                        end
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_STREAM_WRITER_STATS_EN
    logic [31:0] words_written;
    logic        overflow;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            words_written <= '0;
            overflow      <= 1'b0;
        end else begin
            if (start_edge) begin
                words_written <= '0;
            end else if (pop) begin
                words_written <= words_written + 1'b1;
            end
            if (stream_s_valid_i && !stream_s_ready_o) begin
                overflow <= 1'b1;
            end
        end
    end

    assign words_written_o = words_written;
    assign overflow_o      = overflow;
`endif

endmodule

// File: doc/wb_stream_writer.md
Name: wb_stream_writer

Overview:
- Upstream stage of the streamer datapath.
- Accepts a valid/ready word stream and buffers it in a synchronous FIFO.
- Emits Wishbone incrementing-burst write cycles into a memory buffer described by start address and size.
- Its master port drives the Wishbone slave that consumes burst writes.

Parameters:
- WB_AW, 32, Wishbone address width.
- WB_DW, 32, Wishbone and stream data width; must be a multiple of 8.
- FIFO_AW, 6, FIFO depth is 2**FIFO_AW words.
- MAX_BURST_LEN, 8, maximum beats per Wishbone cycle; must be ≤ 2**FIFO_AW and ≥ 1.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- stream_s_data_i  in  WB_DW  stream word.
- stream_s_valid_i  in  1  word valid.
- stream_s_ready_o  out  1  FIFO not full.
- enable_i  in  1  rising edge (IDLE only) latches cfg and starts a transfer.
- start_adr_i  in  WB_AW  byte address of first word; word-aligned.
- buf_size_i  in  WB_AW  transfer length in words.
- busy_o  out  1  transfer in progress.
- irq_o  out  1  one-cycle pulse on transfer completion.
- err_o  out  1  sticky; set on wbm_err_i, cleared on next start.
- wbm_adr_o  out  WB_AW.
- wbm_dat_o  out  WB_DW.
- wbm_sel_o  out  WB_DW/8.
- wbm_we_o  out  1.
- wbm_cyc_o  out  1.
- wbm_stb_o  out  1.
- wbm_cti_o  out  3.
- wbm_bte_o  out  2.
- wbm_ack_i  in  1.
- wbm_err_i  in  1.

Behaviour:
- Interface: one clock, wb_clk_i; reset wb_rst_i is synchronous and active-high.
- Reset values:
  - All outputs 0 except stream_s_ready_o, which is 1 once out of reset (FIFO empty).
  - FIFO flushed; state IDLE.
  - Reset mid-burst drops cyc/stb at the next edge; no further beats are issued.
- Stream side:
  - A word is written when valid && ready.
  - ready = !full, registered from FIFO count.
  - Accepted regardless of state; words arriving in IDLE are kept for the next transfer.
- FSM states:
  - IDLE: on enable_i rising edge, latch adr and remaining = buf_size_i, clear err_o, then go to WAIT. If buf_size_i == 0, go to DONE instead.
  - WAIT: compute blen = min(MAX_BURST_LEN, remaining). When fifo_count ≥ blen, go to BURST next cycle, asserting cyc = stb = we = 1 and sel = all ones.
  - BURST:
    - wbm_dat_o = FIFO head (first-word-fall-through).
    - cti = 3'b010 for all beats except the last, which is 3'b111.
    - bte = 2'b00 (linear).
    - Each ack pops the FIFO, adds WB_DW/8 to adr, and decrements remaining and beat counter.
    - Ack on the last beat drops cyc/stb in the same edge. Then go to DONE if remaining == 0, else back to WAIT. A new cycle never starts in the cycle following a drop.
    - wbm_err_i terminates the cycle immediately: set err_o, do not pop the FIFO, go to IDLE, no irq.
    - ack and err together: err wins.
  - DONE: irq_o = 1 for exactly one cycle, then IDLE. busy_o = 1 in WAIT/BURST/DONE.
- Boundary conditions:
  - The FIFO push/pop happens in the same cycle when full: push is blocked by ready = 0, pop proceeds.
  - Address arithmetic wraps modulo 2**WB_AW.
  - enable_i edges outside IDLE are ignored.
  - A FIFO underrun is impossible because a burst starts only when count ≥ blen.

Optional Feature:
- WB_STREAM_WRITER_STATS_EN
  - Defined: adds output words_written_o (32 bits), counting acked beats since the last start (cleared on start and reset). Also adds overflow_o, a sticky flag set when stream_s_valid_i is high while ready is 0.
  - Undefined: neither port nor counter exists.

Decomposition:
- Package wb_stream_pkg:
  - CTI_CLASSIC = 3'b000, CTI_INC = 3'b010, CTI_EOB = 3'b111.
  - BTE_LINEAR = 2'b00.
  - FSM state enum {IDLE, WAIT, BURST, DONE}.
- Sub-module stream_fifo:
  - Synchronous, first-word-fall-through, parameterised by WB_DW and FIFO_AW.
  - Outputs full, empty, count.

Test Plan:
- buf_size = 16, adr = 0x1000, MAX = 8, stream 0..15 → exactly 2 bursts of 8 beats. cti 010×7 then 111. Addresses 0x1000..0x103C. Data in order. One irq pulse.
- buf_size = 10 → bursts of 8 and 2 beats; the second burst starts at 0x1020 with cti 010, 111.
- buf_size = 1 → a single beat with cti = 111. buf_size = 0 → irq one cycle after start, with no cyc.
- Slave inserts 3 wait states per beat and stream stalls for 20 cycles mid-transfer → no stb while the FIFO holds fewer than blen words. Data intact; ready drops when 64 words are buffered.
- err asserted on beat 3 of burst 1 → cyc drops next edge, err_o = 1, busy_o = 0, no irq. The next start clears err_o.
- Reset asserted mid-burst → cyc/stb = 0 at the next edge; FIFO empty; ready = 1.
